// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants and decoder state encodings
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_digit_dec.sv
// rtl/seg7_digit_dec.sv - combinational active-low 7-segment pattern to digit decoder
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_legal,
    output logic       o_blank
);

    always_comb begin
        o_digit = 4'd0;
        o_legal = 1'b1;
        o_blank = 1'b0;
        case (i_seg)
            SEG_0:     o_digit = 4'd0;
            SEG_1:     o_digit = 4'd1;
            SEG_2:     o_digit = 4'd2;
            SEG_3:     o_digit = 4'd3;
            SEG_4:     o_digit = 4'd4;
            SEG_5:     o_digit = 4'd5;
            SEG_6:     o_digit = 4'd6;
            SEG_7:     o_digit = 4'd7;
            SEG_8:     o_digit = 4'd8;
            SEG_9:     o_digit = 4'd9;
            SEG_BLANK: begin
                o_legal = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg2hex.sv
// rtl/seg2hex.sv - two-digit 7-segment to hex decoder with stability filter
// Optional error counter port o_err_cnt enabled by SEG2HEX_ERR_CNT_EN.
module seg2hex
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_seg_1,
    input  logic [6:0] i_seg_0,
    output logic [3:0] o_hex,
    output logic       o_valid,
    output logic       o_err
`ifdef SEG2HEX_ERR_CNT_EN
    ,
    output logic [7:0] o_err_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [13:0]      seg_q, seg_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       hex_q, hex_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [13:0] seg_in;
    logic        match;
    logic [3:0]  t_digit, u_digit;
    logic        t_legal, u_legal, t_blank, u_blank;
    logic        tens_ok, units_ok, pair_ok;
    logic [4:0]  pair_val;

    assign seg_in = {i_seg_1, i_seg_0};
    assign match  = (seg_in == seg_q);

    // Decode from the sample register; it equals the inputs whenever a decode fires.
    seg7_digit_dec u_tens (
        .i_seg   (seg_q[13:7]),
        .o_digit (t_digit),
        .o_legal (t_legal),
        .o_blank (t_blank)
    );

    seg7_digit_dec u_units (
        .i_seg   (seg_q[6:0]),
        .o_digit (u_digit),
        .o_legal (u_legal),
        .o_blank (u_blank)
    );

    always_comb begin
        tens_ok  = t_blank | (t_legal & (t_digit <= 4'd1));
        units_ok = u_legal & ~u_blank;
        pair_val = {1'b0, u_digit} + ((t_legal && t_digit == 4'd1) ? 5'd10 : 5'd0);
        pair_ok  = tens_ok & units_ok & (pair_val <= 5'd15);
    end

    always_comb begin
        seg_d   = seg_in;
        state_d = state_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (!match) begin
            state_d = SETTLE;
            cnt_d   = '0;
        end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = LOCKED;
                if (pair_ok) begin
                    hex_d   = pair_val[3:0];
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seg_q   <= {SEG_BLANK, SEG_BLANK};
            state_q <= SETTLE;
            cnt_q   <= '0;
            hex_q   <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_hex   = hex_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;

`ifdef SEG2HEX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) err_cnt_q <= 8'd0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg2hex.sv
// tb/tb_seg2hex.sv - self-checking bench for seg2hex (STABLE_CYCLES=4 and =1 side by side)
module tb_seg2hex;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg1, seg0;
    logic [3:0] hex4, hex1;
    logic       valid4, valid1, err4, err1;
`ifdef SEG2HEX_ERR_CNT_EN
    logic [7:0] cnt4, cnt1;
`endif

    always #5 clk = ~clk;

    seg2hex #(.STABLE_CYCLES(4), .CNT_W(8)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_seg_1(seg1), .i_seg_0(seg0),
        .o_hex(hex4), .o_valid(valid4), .o_err(err4)
`ifdef SEG2HEX_ERR_CNT_EN
        , .o_err_cnt(cnt4)
`endif
    );

    seg2hex #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_seg_1(seg1), .i_seg_0(seg0),
        .o_hex(hex1), .o_valid(valid1), .o_err(err1)
`ifdef SEG2HEX_ERR_CNT_EN
        , .o_err_cnt(cnt1)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] BLANK = 7'h7F;

    // Reference: count how many consecutive edges the same pair has been sampled;
    // a decision is due on the edge where that run reaches S+1.
    int          m_s     [2] = '{4, 1};
    int          m_run   [2];
    logic [13:0] m_prev  [2];
    int          m_hex   [2];
    int          m_valid [2];
    int          m_err   [2];
    int          m_ecnt  [2];
    int          pulses4, pulses1, edge_idx, pulse_at;

    function automatic int digit_of(logic [6:0] p);
        for (int i = 0; i < 10; i++) if (codes[i] == p) return i;
        return -1;
    endfunction

    function automatic int pair_value(logic [6:0] t, logic [6:0] u);
        int tv, uv;
        uv = digit_of(u);
        if (t == BLANK || t == codes[0]) tv = 0;
        else if (t == codes[1])          tv = 10;
        else                             tv = -1;
        if (tv < 0 || uv < 0 || tv + uv > 15) return -1;
        return tv + uv;
    endfunction

    task automatic model_edge();
        int v;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            m_err[k]   = 0;
            if (rst) begin
                m_prev[k] = {BLANK, BLANK};
                m_run[k]  = 1;
                m_hex[k]  = 0;
                m_ecnt[k] = 0;
            end else begin
                if ({seg1, seg0} == m_prev[k]) begin
                    if (m_run[k] < 1000) m_run[k]++;
                end else begin
                    m_prev[k] = {seg1, seg0};
                    m_run[k]  = 1;
                end
                if (m_run[k] == m_s[k] + 1) begin
                    v = pair_value(seg1, seg0);
                    if (v >= 0) begin
                        m_hex[k]   = v;
                        m_valid[k] = 1;
                    end else begin
                        m_err[k] = 1;
                        if (m_ecnt[k] < 255) m_ecnt[k]++;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        chk("hex4",   {28'd0, hex4},   m_hex[0]);
        chk("valid4", {31'd0, valid4}, m_valid[0]);
        chk("err4",   {31'd0, err4},   m_err[0]);
        chk("hex1",   {28'd0, hex1},   m_hex[1]);
        chk("valid1", {31'd0, valid1}, m_valid[1]);
        chk("err1",   {31'd0, err1},   m_err[1]);
        chk("excl4",  {31'd0, valid4 & err4}, 0);
`ifdef SEG2HEX_ERR_CNT_EN
        chk("ecnt4",  {24'd0, cnt4}, m_ecnt[0]);
        chk("ecnt1",  {24'd0, cnt1}, m_ecnt[1]);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
        edge_idx++;
        if (valid4 || err4) begin
            pulses4++;
            if (pulse_at < 0) pulse_at = edge_idx;
        end
        if (valid1 || err1) pulses1++;
    endtask

    task automatic hold(input logic [6:0] t, input logic [6:0] u, input int n);
        seg1 = t;
        seg0 = u;
        repeat (n) step();
    endtask

    task automatic clear_counts();
        pulses4 = 0; pulses1 = 0; edge_idx = 0; pulse_at = -1;
    endtask

    initial begin
        int v, len, sel;
        logic [6:0] t, u;

        rst = 1'b1; seg1 = BLANK; seg0 = codes[3];
        clear_counts();
        repeat (2) step();
        chk("rst_hex4", {28'd0, hex4}, 0);
        chk("rst_valid4", {31'd0, valid4}, 0);
        rst = 1'b0;

        // Hold 03: one pulse, 5 edges after first capture
        clear_counts();
        hold(BLANK, codes[3], 12);
        chk("p1_pulses", pulses4, 1);
        chk("p1_latency", pulse_at, 5);
        chk("p1_hex", {28'd0, hex4}, 3);

        // Sweep 15 down to 0
        for (int val = 15; val >= 0; val--) begin
            clear_counts();
            hold((val >= 10) ? codes[1] : BLANK, codes[val % 10], 20);
            chk("sweep_pulses4", pulses4, 1);
            chk("sweep_pulses1", pulses1, 1);
            chk("sweep_hex", {28'd0, hex4}, val);
        end

        // Value 16: error, hex retained
        clear_counts();
        hold(codes[1], codes[6], 15);
        chk("v16_pulses", pulses4, 1);
        chk("v16_err_only", {31'd0, err4}, 0);
        chk("v16_hex_kept", {28'd0, hex4}, 0);

        // Glitching units: no pulses from the 4-cycle instance
        clear_counts();
        for (int i = 0; i < 10; i++) hold(BLANK, (i % 2 == 0) ? codes[3] : codes[4], 3);
        chk("glitch_pulses4", pulses4, 0);
        hold(BLANK, codes[4], 10);
        chk("glitch_hex", {28'd0, hex4}, 4);

        // Reset at cnt=2 mid-settle
        clear_counts();
        seg1 = BLANK; seg0 = codes[5];
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("mid_rst_hex", {28'd0, hex4}, 0);
        rst = 1'b0;
        clear_counts();
        hold(BLANK, codes[5], 8);
        chk("post_rst_latency", pulse_at, 5);
        chk("post_rst_hex", {28'd0, hex4}, 5);

        // Randomized segments
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 65) begin
                v = $urandom_range(0, 15);
                t = (v >= 10) ? codes[1] : (($urandom_range(0, 1) == 1) ? codes[0] : BLANK);
                u = codes[v % 10];
            end else if (sel < 85) begin
                t = codes[$urandom_range(0, 9)];
                u = codes[$urandom_range(0, 9)];
            end else begin
                t = 7'($urandom);
                u = 7'($urandom);
            end
            rst = ($urandom_range(0, 99) < 2);
            len = $urandom_range(1, 8);
            seg1 = t; seg0 = u;
            step();
            rst = 1'b0;
            repeat (len - 1) step();
        end

`ifdef SEG2HEX_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            hold(codes[2], codes[$urandom_range(0, 9)], 10);
            hold(BLANK, BLANK, 10);
        end
        chk("ecnt_sat", {24'd0, cnt4}, 255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg2hex.md
# seg2hex

Seven-segment-to-hex decoder: the receive-side counterpart of the hex-to-two-digit display encoder. It watches a pair of 7-segment digit patterns (tens, units) and recovers the 4-bit value 0..15 they display. A pattern must stay stable for a programmable number of clock cycles before it is accepted. Each accepted stable pattern produces exactly one valid pulse or one error pulse. The block sits on the capture/loopback side of the display path and lets the bench or on-chip self-test close the loop on the encoder.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples required before decode; legal range 1..255.
- CNT_W, 8, stability counter width; must hold STABLE_CYCLES-1.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_seg_1  in  7  tens-digit pattern, active-low, bit0=a … bit6=g.
- i_seg_0  in  7  units-digit pattern, same encoding.
- o_hex  out  4  last accepted value; holds between acceptances.
- o_valid  out  1  one-cycle pulse when o_hex is updated.
- o_err  out  1  one-cycle pulse when a stable pattern is illegal; o_hex unchanged.
- o_err_cnt  out  8  present only with SEG2HEX_ERR_CNT_EN.

## Operation
- Active-low digit codes (g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Blank is 7F.
- Tens digit: blank or "0" means 0; "1" means 10. Any other tens pattern is illegal.
- Units digit: 0..9 are legal. Blank or any other code is illegal.
- Legal pair value = tens*10 + units. A value above 15 (tens "1" with units 6..9) is illegal.
- Sample register r_seg {tens, units} captures the inputs every cycle.
- States and transitions:
  - SETTLE: entered on reset or on any input/sample mismatch; cnt cleared to 0.
    - Each cycle the inputs equal r_seg: cnt increments.
    - Cycle the inputs equal r_seg and cnt == STABLE_CYCLES-1: decode, pulse o_valid or o_err, go to LOCKED.
  - LOCKED: no pulses.
    - Any mismatch between inputs and r_seg: go to SETTLE, cnt=0.
- Identical pattern held indefinitely yields exactly one pulse.
- A change back to a previously accepted value still re-decodes and pulses again.
- o_valid and o_err are never high in the same cycle.
- Reset values:
  - o_hex=0, o_valid=0, o_err=0, o_err_cnt=0.
  - r_seg=7F/7F, state SETTLE, cnt=0.
- Reset mid-settle: the pending detection is discarded and no pulse is emitted.
- Reset has priority over all other events.

## Timing
- Inputs change before edge E0; E0 captures them (mismatch → SETTLE, cnt=0).
- o_valid/o_err asserts after edge E0+STABLE_CYCLES and lasts exactly one cycle.
- Total latency is STABLE_CYCLES+1 edges from the first edge on which the new pattern is present.
- o_hex updates on the same edge o_valid rises.
- A glitch of fewer than STABLE_CYCLES+1 cycles produces no pulse, and the count restarts on every change.
- STABLE_CYCLES=1: pulse after E0+1.
- Inputs are treated as synchronous to i_clk; no CDC synchronizer in this block.

## Configuration
- SEG2HEX_ERR_CNT_EN defined: o_err_cnt exists.
  - 8-bit counter, increments on every o_err pulse.
  - Saturates at 255 and is cleared only by reset.
- SEG2HEX_ERR_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package/header seg7_pkg:
  - SEG_0..SEG_9 and SEG_BLANK active-low constants.
  - State encodings SETTLE/LOCKED.
- The matching encoder uses the same seg7_pkg constants.
- Sub-module seg7_digit_dec: combinational, 7-bit pattern → 4-bit digit plus legal flag, with blank reported as a separate flag. It is instantiated twice.
- Top level holds r_seg, cnt, the state register, the range check and the output registers.

## Test plan
- Reset, then hold tens=7F, units=30 with STABLE_CYCLES=4 → one o_valid 5 edges after the first capture, o_hex=3; no further pulses while held.
- Sweep 15 down to 0 (tens 79 / units 12 … tens 7F / units 40), each held 20 cycles → o_hex sequence F,E,…,0, exactly one o_valid each.
- Tens=79, units=02 (value 16) held → single o_err, o_hex retains the previous value; with the macro defined, o_err_cnt=1.
- Units toggles 30↔19 every 3 cycles for 30 cycles → no pulses. Then hold 19 → o_valid, o_hex=4.
- Assert i_rst at cnt=2 during settle → outputs return to reset values and no pulse. After release, a held pattern pulses after the full STABLE_CYCLES+1 edges.
- 300 illegal patterns (tens 24) alternating with blank, each held 10 cycles, macro defined → o_err_cnt saturates at 255.
